rf_write_arbiter: RTL

// - Shares the register file's single write port between two writers: pipeline WB stage (fixed priority, cannot stall) and multi-cycle MUL/DIV unit (valid/ready).
// - Holds MD results in a small FIFO until a free WB slot appears; forces a pipeline bubble if an MD result starves.
// - Keeps a 32-entry pending-write scoreboard so the hazard unit can stall readers of in-flight MD destinations.
// - Sits between WB/MD units and the register file write inputs (RegWrite/RDaddr/RDdata).

---
 rtl/mips_pkg.sv | 12 +
 rtl/md_wb_fifo.sv | 67 ++++++
 rtl/rf_write_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths and arbiter state encoding
package mips_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int REG_NUM    = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } arb_state_e;
endpackage

// File: rtl/md_wb_fifo.sv
// rtl/md_wb_fifo.sv - synchronous FIFO holding MD results awaiting a write-port slot
module md_wb_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data_i;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end
endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - shares the RF write port between WB (priority) and MD results
module rf_write_arbiter
   import mips_pkg::*;
#(
   parameter int MD_DEPTH     = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  wb_we_i,
   input  logic [REG_ADDR_W-1:0] wb_addr_i,
   input  logic [DATA_W-1:0]     wb_data_i,
   input  logic                  md_issue_i,
   input  logic [REG_ADDR_W-1:0] md_issue_addr_i,
   input  logic                  md_valid_i,
   output logic                  md_ready_o,
   input  logic [REG_ADDR_W-1:0] md_addr_i,
   input  logic [DATA_W-1:0]     md_data_i,
   input  logic [REG_ADDR_W-1:0] rs_addr_i,
   input  logic [REG_ADDR_W-1:0] rt_addr_i,
   output logic                  rs_busy_o,
   output logic                  rt_busy_o,
   output logic                  stall_o,
   output logic                  rf_we_o,
   output logic [REG_ADDR_W-1:0] rf_addr_o,
   output logic [DATA_W-1:0]     rf_data_o,
   output logic                  err_o
);
   localparam int CNT_W = $clog2(MD_DEPTH) + 1;

   logic                          fifo_full, fifo_empty, push, pop;
   logic [CNT_W-1:0]              fifo_count;
   logic [REG_ADDR_W+DATA_W-1:0]  head;
   logic [REG_ADDR_W-1:0]         head_addr;
   logic [DATA_W-1:0]             head_data;
   logic [REG_NUM-1:0]            sb_q, sb_d;
   logic                          err_q, err_d;
   arb_state_e                    state_q, state_d;
   logic [3:0]                    wait_cnt_q, wait_cnt_d;
   logic                          drains_empty;

   md_wb_fifo #(
      .WIDTH (REG_ADDR_W + DATA_W),
      .DEPTH (MD_DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push),
      .push_data_i ({md_addr_i, md_data_i}),
      .pop_i       (pop),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   assign head_addr  = head[REG_ADDR_W+DATA_W-1:DATA_W];
   assign head_data  = head[DATA_W-1:0];
   assign md_ready_o = !rst_i && !fifo_full;
   // Results for r0 complete the handshake but are never queued.
   assign push       = md_valid_i && md_ready_o && (md_addr_i != '0);
   assign pop        = !rst_i && !wb_we_i && !fifo_empty;

   always_comb begin
      rf_we_o   = 1'b0;
      rf_addr_o = '0;
      rf_data_o = '0;
      if (!rst_i) begin
         if (wb_we_i) begin
            rf_we_o   = 1'b1;
            rf_addr_o = wb_addr_i;
            rf_data_o = wb_data_i;
         end else if (!fifo_empty) begin
            rf_we_o   = 1'b1;
            rf_addr_o = head_addr;
            rf_data_o = head_data;
         end
      end
   end

   // Issue is applied after the drain clear so a same-cycle reissue keeps the bit set.
   always_comb begin
      sb_d  = sb_q;
      err_d = err_q;
      if (pop) begin
         sb_d[head_addr] = 1'b0;
      end
      if (md_issue_i && (md_issue_addr_i != '0)) begin
         sb_d[md_issue_addr_i] = 1'b1;
         if (sb_q[md_issue_addr_i]) begin
            err_d = 1'b1;
         end
      end
   end

   assign rs_busy_o = (rs_addr_i != '0) && sb_q[rs_addr_i];
   assign rt_busy_o = (rt_addr_i != '0) && sb_q[rt_addr_i];
   assign err_o     = err_q;
   assign stall_o   = !rst_i && (state_q == DRAIN);

   assign drains_empty = (fifo_count == CNT_W'(1)) && !push;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         IDLE: begin
            wait_cnt_d = '0;
            if (push) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (pop) begin
               wait_cnt_d = '0;
               state_d    = drains_empty ? IDLE : WAIT;
            end else begin
               wait_cnt_d = wait_cnt_q + 4'd1;
               if (wait_cnt_d == 4'(STARVE_LIMIT)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pop) begin
               wait_cnt_d = '0;
               state_d    = drains_empty ? IDLE : WAIT;
            end
         end
         default: begin
            state_d    = IDLE;
            wait_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sb_q       <= '0;
         err_q      <= 1'b0;
         state_q    <= IDLE;
         wait_cnt_q <= '0;
      end else begin
         sb_q       <= sb_d;
         err_q      <= err_d;
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end
endmodule
